// File: rtl/led_ring_checker.sv
// led_ring_checker
//
// Receive-side self-check for a rotating one-hot LED ring. Each sample taken
// on i_valid is decoded to a lit position. The first clean sample seeds the
// position, the second fixes the rotation direction, and every later sample
// must advance exactly one position (modulo NB_LEDS) in that direction.
// Any violation moves the block into a sticky ERROR state.
//
// Optional build macro:
//   LEDCHK_RESYNC_EN - when defined, a one-hot sample seen in ERROR reseeds
//                      the position and the checker tries to lock again.
//                      o_error stays sticky until i_reset.
//
// Ports:
//   clock         in   system clock, rising edge
//   i_reset       in   synchronous active-high reset (overrides i_valid)
//   i_led         in   ring pattern, sampled only when i_valid=1
//   i_valid       in   sample strobe, one per generator shift
//   o_index       out  lit position of the last accepted sample
//   o_dir         out  0 = ascending (bit i -> i+1), 1 = descending
//   o_locked      out  high only while tracking a locked rotation
//   o_error       out  sticky error flag
//   o_err_pulse   out  one-cycle pulse on each entry into ERROR
//   o_step_count  out  valid steps since lock, saturating
//
// All outputs are registered: they reflect a sample one clock after the
// edge that accepted it.

module led_ring_checker #(
  parameter int NB_LEDS  = 4,
  parameter int NB_COUNT = 8,
  localparam int NB_IDX  = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [NB_LEDS-1:0]  i_led,
  input  logic                i_valid,
  output logic [NB_IDX-1:0]   o_index,
  output logic                o_dir,
  output logic                o_locked,
  output logic                o_error,
  output logic                o_err_pulse,
  output logic [NB_COUNT-1:0] o_step_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NB_LEDS - 1);

  state_t                state_q, state_d;
  logic [NB_IDX-1:0]     index_q, index_d;
  logic                  dir_q, dir_d;
  logic                  locked_q, locked_d;
  logic                  error_q, error_d;
  logic                  pulse_q, pulse_d;
  logic [NB_COUNT-1:0]   count_q, count_d;

  // Sample decode
  logic                  one_hot;
  logic [NB_IDX-1:0]     idx;
  logic [NB_IDX-1:0]     prev_up;
  logic [NB_IDX-1:0]     prev_dn;
  logic [NB_IDX-1:0]     expected;

  // A value is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  assign one_hot = (i_led != '0) && ((i_led & (i_led - NB_LEDS'(1))) == '0);

  // Neighbours of the stored position with explicit wrap, so the ring need
  // not be a power of two.
  assign prev_up  = (index_q == LAST_IDX) ? '0 : index_q + NB_IDX'(1);
  assign prev_dn  = (index_q == '0) ? LAST_IDX : index_q - NB_IDX'(1);
  assign expected = dir_q ? prev_dn : prev_up;

  // Position of the highest set bit; only meaningful when one_hot is true.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NB_LEDS; i++) begin
      if (i_led[i]) idx = NB_IDX'(i);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    index_d  = index_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    error_d  = error_q;
    pulse_d  = 1'b0;
    count_d  = count_q;

    if (i_valid) begin
      unique case (state_q)
        IDLE: begin
          // Non-one-hot samples here are treated as start-up garbage.
          if (one_hot) begin
            index_d = idx;
            state_d = SYNC;
          end
        end

        SYNC: begin
          // Ascending is tested first, so a two-LED ring locks ascending.
          if (one_hot && idx == prev_up) begin
            index_d  = idx;
            dir_d    = 1'b0;
            count_d  = NB_COUNT'(1);
            locked_d = 1'b1;
            state_d  = TRACK;
          end else if (one_hot && idx == prev_dn) begin
            index_d  = idx;
            dir_d    = 1'b1;
            count_d  = NB_COUNT'(1);
            locked_d = 1'b1;
            state_d  = TRACK;
          end else begin
            state_d  = ERROR;
            error_d  = 1'b1;
            pulse_d  = 1'b1;
            locked_d = 1'b0;
          end
        end

        TRACK: begin
          if (one_hot && idx == expected) begin
            index_d = idx;
            if (count_q != '1) count_d = count_q + NB_COUNT'(1);
          end else begin
            state_d  = ERROR;
            error_d  = 1'b1;
            pulse_d  = 1'b1;
            locked_d = 1'b0;
          end
        end

        ERROR: begin
`ifdef LEDCHK_RESYNC_EN
          // Reseed from a clean sample; o_error deliberately stays set.
          if (one_hot) begin
            index_d = idx;
            count_d = '0;
            state_d = SYNC;
          end
`else
          // Terminal: only i_reset leaves this state.
`endif
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      error_q  <= error_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
    end
  end

  assign o_index      = index_q;
  assign o_dir        = dir_q;
  assign o_locked     = locked_q;
  assign o_error      = error_q;
  assign o_err_pulse  = pulse_q;
  assign o_step_count = count_q;

endmodule

// File: tb/tb_led_ring_checker.sv
// Testbench for led_ring_checker (NB_LEDS=4, NB_COUNT=3).
// Stimulus is driven on the falling edge; each driven cycle pushes the
// expected register outputs after the next rising edge into a queue. A
// separate monitor pops and compares one entry per rising edge.

module tb_led_ring_checker;

  localparam int NB_LEDS  = 4;
  localparam int NB_COUNT = 3;
  localparam int NB_IDX   = 2;

  logic                clock;
  logic                i_reset;
  logic [NB_LEDS-1:0]  i_led;
  logic                i_valid;
  logic [NB_IDX-1:0]   o_index;
  logic                o_dir;
  logic                o_locked;
  logic                o_error;
  logic                o_err_pulse;
  logic [NB_COUNT-1:0] o_step_count;

  led_ring_checker #(
    .NB_LEDS  (NB_LEDS),
    .NB_COUNT (NB_COUNT)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_led        (i_led),
    .i_valid      (i_valid),
    .o_index      (o_index),
    .o_dir        (o_dir),
    .o_locked     (o_locked),
    .o_error      (o_error),
    .o_err_pulse  (o_err_pulse),
    .o_step_count (o_step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string             name;
    logic [NB_IDX-1:0] index;
    logic              dir;
    logic              locked;
    logic              error;
    logic              pulse;
    logic [NB_COUNT-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (o_index !== e.index || o_dir !== e.dir || o_locked !== e.locked ||
        o_error !== e.error || o_err_pulse !== e.pulse || o_step_count !== e.count) begin
      n_errors++;
      $display("FAIL %s: got idx=%0d dir=%0b lock=%0b err=%0b pulse=%0b cnt=%0d, want idx=%0d dir=%0b lock=%0b err=%0b pulse=%0b cnt=%0d",
               name, o_index, o_dir, o_locked, o_error, o_err_pulse, o_step_count,
               e.index, e.dir, e.locked, e.error, e.pulse, e.count);
    end
  endtask

  // Monitor: one expected entry per rising edge once stimulus is flowing.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, e);
      end
    end
  end

  // Drive one cycle and record what the outputs must be after the next edge.
  task automatic apply(input string name, input logic rst, input logic vld,
                       input logic [NB_LEDS-1:0] led,
                       input int idx, input logic dir, input logic lock,
                       input logic err, input logic pulse, input int cnt);
    exp_t e;
    @(negedge clock);
    i_reset = rst;
    i_valid = vld;
    i_led   = led;
    e.name   = name;
    e.index  = NB_IDX'(idx);
    e.dir    = dir;
    e.locked = lock;
    e.error  = err;
    e.pulse  = pulse;
    e.count  = NB_COUNT'(cnt);
    exp_q.push_back(e);
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_led   = '0;

    // 1: ascending lock and wrap 3->0
    apply("t1_rst",  1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t1_s0",   0, 1, 4'b0001, 0, 0, 0, 0, 0, 0);
    apply("t1_s1",   0, 1, 4'b0010, 1, 0, 1, 0, 0, 1);
    apply("t1_s2",   0, 1, 4'b0100, 2, 0, 1, 0, 0, 2);
    apply("t1_s3",   0, 1, 4'b1000, 3, 0, 1, 0, 0, 3);
    apply("t1_wrap", 0, 1, 4'b0001, 0, 0, 1, 0, 0, 4);

    // 2: descending lock and wrap 0->3
    apply("t2_rst",  1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t2_s0",   0, 1, 4'b1000, 3, 0, 0, 0, 0, 0);
    apply("t2_s1",   0, 1, 4'b0100, 2, 1, 1, 0, 0, 1);
    apply("t2_s2",   0, 1, 4'b0010, 1, 1, 1, 0, 0, 2);
    apply("t2_s3",   0, 1, 4'b0001, 0, 1, 1, 0, 0, 3);
    apply("t2_wrap", 0, 1, 4'b1000, 3, 1, 1, 0, 0, 4);

    // 3: skip in TRACK -> single error pulse, outputs hold
    apply("t3_rst",   1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t3_s0",    0, 1, 4'b0001, 0, 0, 0, 0, 0, 0);
    apply("t3_s1",    0, 1, 4'b0010, 1, 0, 1, 0, 0, 1);
    apply("t3_skip",  0, 1, 4'b1000, 1, 0, 0, 1, 1, 1);
    apply("t3_gap",   0, 0, 4'b0000, 1, 0, 0, 1, 0, 1);
    apply("t3_bad2",  0, 1, 4'b0000, 1, 0, 0, 1, 0, 1);
`ifdef LEDCHK_RESYNC_EN
    apply("t3_after", 0, 1, 4'b0100, 2, 0, 0, 1, 0, 0);
`else
    apply("t3_after", 0, 1, 4'b0100, 1, 0, 0, 1, 0, 1);
`endif

    // 4: garbage ignored in IDLE, lock, zero pattern in TRACK -> error
    apply("t4_rst",   1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t4_g0",    0, 1, 4'b0011, 0, 0, 0, 0, 0, 0);
    apply("t4_g1",    0, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t4_s0",    0, 1, 4'b0001, 0, 0, 0, 0, 0, 0);
    apply("t4_s1",    0, 1, 4'b0010, 1, 0, 1, 0, 0, 1);
    apply("t4_zero",  0, 1, 4'b0000, 1, 0, 0, 1, 1, 1);
`ifdef LEDCHK_RESYNC_EN
    apply("t4_resync", 0, 1, 4'b0100, 2, 0, 0, 1, 0, 0);
    apply("t4_relock", 0, 1, 4'b1000, 3, 0, 1, 1, 0, 1);
`else
    apply("t4_hold0",  0, 1, 4'b0100, 1, 0, 0, 1, 0, 1);
    apply("t4_hold1",  0, 1, 4'b1000, 1, 0, 0, 1, 0, 1);
`endif

    // 7: repeated position in SYNC is an error
    apply("t7_rst",   1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t7_s0",    0, 1, 4'b0010, 1, 0, 0, 0, 0, 0);
    apply("t7_same",  0, 1, 4'b0010, 1, 0, 0, 1, 1, 0);

    // 5: ten ascending steps with 0-3 idle cycles, count saturates at 7
    apply("t5_rst",   1, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    apply("t5_s0",    0, 1, 4'b0001, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      int c;
      c = (k > 7) ? 7 : k;
      apply($sformatf("t5_step%0d", k), 0, 1, 4'b0001 << (k % 4),
            k % 4, 0, 1, 0, 0, c);
      for (int g = 0; g < (k % 4); g++)
        apply($sformatf("t5_gap%0d_%0d", k, g), 0, 0, 4'b1111,
              k % 4, 0, 1, 0, 0, c);
    end

    // 6: reset while tracking, with a valid sample present, then re-lock
    apply("t6_rst",   1, 1, 4'b1000, 0, 0, 0, 0, 0, 0);
    apply("t6_s0",    0, 1, 4'b0100, 2, 0, 0, 0, 0, 0);
    apply("t6_s1",    0, 1, 4'b1000, 3, 0, 1, 0, 0, 1);

    @(negedge clock);
    i_valid = 1'b0;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_ring_checker.md
Name: led_ring_checker

Overview:
- Receive-side monitor for a rotating one-hot LED ring pattern, such as the output of the team's LED shift-register block.
- Samples the pattern on each valid strobe and decodes the lit position.
- Locks onto the rotation direction, then checks that every subsequent step advances exactly one position with wrap-around.
- Reports position, direction, lock, step count and errors. Sits between the pattern generator and the LED/debug outputs, as a self-check.

Parameters:
NB_LEDS, 4, ring width; must be >= 2.
NB_COUNT, 8, width of saturating step counter.
NB_IDX, $clog2(NB_LEDS), width of decoded index; derived, not overridden.

Ports:
clock  in  1  system clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_led  in  NB_LEDS  ring pattern; sampled only when i_valid=1.
i_valid  in  1  sample strobe (one per generator shift).
o_index  out  NB_IDX  decoded lit-bit position of last accepted sample.
o_dir  out  1  0 = ascending (bit i -> i+1), 1 = descending.
o_locked  out  1  high only in TRACK.
o_error  out  1  sticky error flag.
o_err_pulse  out  1  one-cycle pulse on the edge an error is detected.
o_step_count  out  NB_COUNT  valid steps since lock, saturating.

Behaviour:
- One clock; reset synchronous and active-high. All outputs registered; 1-cycle latency from sampling edge.
- Reset values: o_index=0, o_dir=0, o_locked=0, o_error=0, o_err_pulse=0, o_step_count=0, state=IDLE. Reset mid-operation has the same effect on the next edge and overrides i_valid.
- one_hot = exactly one bit of i_led set.
- idx = position of the set bit.
- prev = stored index.
- "+1"/"-1" are modulo NB_LEDS: NB_LEDS-1 wraps to 0, and 0 wraps to NB_LEDS-1.
- i_valid=0: all state and outputs hold; o_err_pulse=0.
- IDLE, on valid:
  - one_hot: store idx, o_index<=idx, go to SYNC.
  - not one_hot: ignored (start-up garbage), stay IDLE, no error.
- SYNC, on valid:
  - idx==prev+1: o_dir<=0, o_step_count<=1, o_locked<=1, go to TRACK.
  - Else idx==prev-1: o_dir<=1, o_step_count<=1, o_locked<=1, go to TRACK.
  - For NB_LEDS=2, +1 and -1 coincide; ascending has priority.
  - idx==prev, not one_hot, or any other idx: go to ERROR.
- TRACK, on valid:
  - Expected = prev+1 if o_dir=0, else prev-1.
  - one_hot and idx==expected: update o_index and prev; o_step_count increments, saturating at 2^NB_COUNT-1.
  - Otherwise: go to ERROR.
- Entering ERROR from any state:
  - o_error<=1, o_err_pulse<=1 for exactly one cycle, o_locked<=0.
  - o_index, o_dir and o_step_count hold their last values.
- ERROR: terminal until i_reset (see Optional Feature). Further valids produce no additional pulses.
- A second mismatch cannot re-pulse while already in ERROR.

Optional Feature:
- Macro: LEDCHK_RESYNC_EN.
- Defined:
  - In ERROR, a valid one_hot sample stores idx, updates o_index, clears o_step_count, and goes to SYNC.
  - Valid non-one-hot samples keep ERROR.
  - o_error remains sticky until i_reset; o_err_pulse fires again on each new ERROR entry.
- Undefined: ERROR is left only by i_reset.

Test Plan:
1. Reset, then valid samples 0001,0010,0100,1000,0001 (NB_LEDS=4) -> o_locked=1 one cycle after the 2nd sample; o_dir=0; o_index 0,1,2,3,0; o_step_count=4; o_error=0.
2. Reset, then 1000,0100,0010,0001,1000 -> o_dir=1; o_index 3,2,1,0,3; o_step_count=4; wrap 0->3 accepted.
3. Lock ascending on 0001,0010, then feed 1000 -> o_err_pulse high exactly one cycle, o_error=1, o_locked=0, o_index stays 1, o_step_count stays 1; a following valid 0100 causes no change (macro undefined).
4. Feed 0011 and 0000 in IDLE -> ignored, state IDLE; then 0001,0010 locks normally; 0000 in TRACK -> error. With LEDCHK_RESYNC_EN, a subsequent 0100 leaves ERROR (o_locked=0, o_index=2, state SYNC), then 1000 -> o_locked=1, o_step_count=1, o_error still 1.
5. NB_COUNT=3, ascending for 10 valid steps with i_valid gaps of 0-3 idle cycles -> o_step_count saturates at 7; no outputs change during gaps; o_error=0.
6. Assert i_reset for one cycle while in TRACK with i_valid=1 -> all outputs return to reset values on that edge; next 0100,1000 re-locks with o_index=3, o_dir=0.
